// File: rtl/push_button_conditioner.sv
// Debounces the four active-low board push-buttons and turns them into clean
// press / release / auto-repeat pulses, paced by a locally generated 1 ms tick.
module push_button_conditioner #(
  parameter int TICK_PERIOD = 50000,
  parameter int SHIFT_LEN   = 10,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100
) (
  input  logic       CLOCK_50_I,
  input  logic       reset,
  input  logic [3:0] PUSH_BUTTON_N_I,
  output logic       tick_1ms_o,
  output logic [3:0] button_status_o,
  output logic [3:0] press_pulse_o,
  output logic [3:0] release_pulse_o,
  output logic [3:0] held_o
);

  localparam int NUM_BUTTONS = 4;
  localparam int DIV_W       = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int MAX_MS      = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int CNT_W       = (MAX_MS > 1) ? $clog2(MAX_MS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_PERIOD - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_MS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_REPEAT
  } btn_state_t;

  logic [NUM_BUTTONS-1:0] sync_meta;
  logic [NUM_BUTTONS-1:0] sync_q;
  logic [DIV_W-1:0]       div_cnt;
  logic                   tick;

  logic [SHIFT_LEN-1:0] shift_q [NUM_BUTTONS];
  logic [SHIFT_LEN-1:0] shift_d [NUM_BUTTONS];
  btn_state_t           state_q [NUM_BUTTONS];
  btn_state_t           state_d [NUM_BUTTONS];
  logic [CNT_W-1:0]     cnt_q   [NUM_BUTTONS];
  logic [CNT_W-1:0]     cnt_d   [NUM_BUTTONS];

  logic [NUM_BUTTONS-1:0] status_d;
  logic [NUM_BUTTONS-1:0] press_d;
  logic [NUM_BUTTONS-1:0] release_d;

  // Buttons are asynchronous to the clock; invert to active-high and resync.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; always_comb logic uses blocking (=).
  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= ~PUSH_BUTTON_N_I;
      sync_q    <= sync_meta;
    end
  end

  assign tick       = (div_cnt == DIV_LAST);
  assign tick_1ms_o = tick;

  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Status and FSM decisions are made from the post-shift register contents so
  // that the registered status and pulses appear in the cycle after the tick.
  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    for (int b = 0; b < NUM_BUTTONS; b++) begin
      shift_d[b]   = shift_q[b];
      status_d[b]  = button_status_o[b];
      state_d[b]   = state_q[b];
      cnt_d[b]     = cnt_q[b];
      press_d[b]   = 1'b0;
      release_d[b] = 1'b0;

      if (tick) begin
        shift_d[b] = SHIFT_LEN'({shift_q[b], sync_q[b]});
        if (&shift_d[b]) begin
          status_d[b] = 1'b1;
        end else if (~|shift_d[b]) begin
          status_d[b] = 1'b0;
        end

        // A falling status is tested before any expiry so a release always
        // pre-empts a hold or repeat pulse landing on the same tick.
        case (state_q[b])
          ST_IDLE: begin
            if (status_d[b]) begin
              state_d[b] = ST_PRESSED;
              press_d[b] = 1'b1;
              cnt_d[b]   = '0;
            end
          end
          ST_PRESSED: begin
            if (!status_d[b]) begin
              state_d[b]   = ST_IDLE;
              release_d[b] = 1'b1;
              cnt_d[b]     = '0;
            end else if (cnt_q[b] == HOLD_LAST) begin
              state_d[b] = ST_REPEAT;
              press_d[b] = 1'b1;
              cnt_d[b]   = '0;
            end else begin
              cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (!status_d[b]) begin
              state_d[b]   = ST_IDLE;
              release_d[b] = 1'b1;
              cnt_d[b]     = '0;
            end else if (cnt_q[b] == REPEAT_LAST) begin
              press_d[b] = 1'b1;
              cnt_d[b]   = '0;
            end else begin
              cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
          end
          default: begin
            state_d[b] = ST_IDLE;
            cnt_d[b]   = '0;
          end
        endcase
      end
    end
  end

  // NOTE: the shift registers are reset on purpose: a button held through
  // reset must be re-qualified by a full window of fresh samples.
  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        shift_q[b] <= '0;
        state_q[b] <= ST_IDLE;
        cnt_q[b]   <= '0;
      end
      button_status_o <= '0;
      press_pulse_o   <= '0;
      release_pulse_o <= '0;
    end else begin
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        shift_q[b] <= shift_d[b];
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
      button_status_o <= status_d;
      press_pulse_o   <= press_d;
      release_pulse_o <= release_d;
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BUTTONS; b++) begin
      held_o[b] = (state_q[b] == ST_REPEAT);
    end
  end

endmodule

// File: tb/tb_push_button_conditioner.sv
// Directed bench for push_button_conditioner with a shortened tick, debounce
// window and repeat timing; expected values are worked out tick by tick.
module tb_push_button_conditioner;

  localparam int TICK_PERIOD = 4;
  localparam int SHIFT_LEN   = 4;
  localparam int HOLD_MS     = 5;
  localparam int REPEAT_MS   = 2;

  logic       CLOCK_50_I = 1'b0;
  logic       reset      = 1'b1;
  logic [3:0] PUSH_BUTTON_N_I = 4'hF;
  logic       tick_1ms_o;
  logic [3:0] button_status_o;
  logic [3:0] press_pulse_o;
  logic [3:0] release_pulse_o;
  logic [3:0] held_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  push_button_conditioner #(
    .TICK_PERIOD(TICK_PERIOD),
    .SHIFT_LEN  (SHIFT_LEN),
    .HOLD_MS    (HOLD_MS),
    .REPEAT_MS  (REPEAT_MS)
  ) dut (
    .CLOCK_50_I     (CLOCK_50_I),
    .reset          (reset),
    .PUSH_BUTTON_N_I(PUSH_BUTTON_N_I),
    .tick_1ms_o     (tick_1ms_o),
    .button_status_o(button_status_o),
    .press_pulse_o  (press_pulse_o),
    .release_pulse_o(release_pulse_o),
    .held_o         (held_o)
  );

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Cycle 1 is the cycle following the last reset edge; the tick lands on
  // every fourth cycle from there.
  always @(posedge CLOCK_50_I) begin
    #1;
    if (reset) cyc = 1;
    else       cyc++;
    check("tick", 4'(tick_1ms_o), 4'(cyc % TICK_PERIOD == 0));
  end

  // Drive the active-high button pattern, run to the next tick (pulses must
  // stay quiet meanwhile), then check the outputs one cycle after it.
  task automatic tk(input string tag, input logic [3:0] btn, input logic [3:0] st,
                    input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] hd);
    bit seen = 1'b0;
    int n    = 0;
    PUSH_BUTTON_N_I = ~btn;
    while (!seen && n < 8) begin
      @(negedge CLOCK_50_I);
      check({tag, "_quiet_press"}, press_pulse_o, 4'b0000);
      check({tag, "_quiet_release"}, release_pulse_o, 4'b0000);
      seen = tick_1ms_o;
      n++;
    end
    check({tag, "_tick_seen"}, 4'(seen), 4'b0001);
    @(negedge CLOCK_50_I);
    check({tag, "_status"}, button_status_o, st);
    check({tag, "_press"}, press_pulse_o, pr);
    check({tag, "_release"}, release_pulse_o, rl);
    check({tag, "_held"}, held_o, hd);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_status"}, button_status_o, 4'b0000);
    check({tag, "_press"}, press_pulse_o, 4'b0000);
    check({tag, "_release"}, release_pulse_o, 4'b0000);
    check({tag, "_held"}, held_o, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pattern [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset held three cycles with buttons idle.
    repeat (3) begin
      @(negedge CLOCK_50_I);
      check_all_zero("rst");
    end
    reset = 1'b0;

    // Clean press of button 0 through hold into auto-repeat.
    repeat (3) tk("a_fill", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tk("a_press", 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    repeat (4) tk("a_hold", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tk("a_rep1", 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    repeat (2) begin
      tk("a_gap", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      tk("a_rep", 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    end
    tk("a_gap", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001);

    // Release during repeat: status holds until the fourth 0 sample.
    tk("a_rel1", 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    tk("a_rel2", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    tk("a_rel3", 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    tk("a_release", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);

    // Second press, released so the fourth 0 sample meets a repeat expiry.
    repeat (3) tk("c_fill", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tk("c_press", 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    repeat (4) tk("c_hold", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tk("c_rep1", 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    tk("c_gap", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    tk("c_rep2", 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    tk("c_rel1", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    tk("c_rel2", 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    tk("c_rel3", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    tk("c_collide", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);

    // Bounce on button 1: 1,0,1,1,0,1 then steady 1.
    for (int i = 0; i < 8; i++) begin
      tk("b_bounce", {2'b00, pattern[i], 1'b0}, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    tk("b_press", {2'b00, pattern[8], 1'b0}, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    repeat (3) tk("b_drop", 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tk("b_release", 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);

    // Buttons 2 and 3 together, then reset while both are held.
    repeat (3) tk("m_fill", 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tk("m_press", 4'b1100, 4'b1100, 4'b1100, 4'b0000, 4'b0000);
    tk("m_hold", 4'b1100, 4'b1100, 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b1;
    @(negedge CLOCK_50_I);
    check_all_zero("m_rst");
    reset = 1'b0;
    repeat (3) tk("r_fill", 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tk("r_press", 4'b1100, 4'b1100, 4'b1100, 4'b0000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/push_button_conditioner.md
# push_button_conditioner

Conditions the four active-low board push-buttons into clean control events for the counter/display stage. It generates its own 1 ms sampling tick from the 50 MHz clock and debounces each button with a symmetric shift-register filter. It emits single-cycle press and release pulses, and auto-repeat press pulses while a button is held. It sits between the board pins and the control logic that toggles stop/start and count direction; downstream logic consumes only its pulses and levels.

## Interface
- TICK_PERIOD, 50000: CLOCK_50_I cycles per sampling tick (1 ms at 50 MHz).
- SHIFT_LEN, 10: debounce samples per button.
- HOLD_MS, 500: ticks a button must stay pressed before auto-repeat starts.
- REPEAT_MS, 100: ticks between auto-repeat pulses.
- CLOCK_50_I  input  1  sole clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of CLOCK_50_I.
- PUSH_BUTTON_N_I  input  4  raw buttons, active-low, asynchronous to the clock.
- tick_1ms_o  output  1  one-cycle strobe, once every TICK_PERIOD cycles.
- button_status_o  output  4  debounced level, 1 = pressed.
- press_pulse_o  output  4  one-cycle pulse on a debounced press and on each auto-repeat.
- release_pulse_o  output  4  one-cycle pulse on a debounced release.
- held_o  output  4  high while the button is in the REPEAT state.

## Operation
- **Input sync:** PUSH_BUTTON_N_I is inverted and passed through a 2-flop synchroniser per bit before any use.
- **Tick divider:**
  - Counter runs 0..TICK_PERIOD-1 and wraps to 0.
  - tick_1ms_o = 1 exactly in the cycle the counter equals TICK_PERIOD-1.
- **Shift register:** on each tick, each button's SHIFT_LEN-bit register shifts left, taking the synchronised sample into bit 0.
- **Debounce (symmetric, with hysteresis):**
  - Status goes to 1 only when all SHIFT_LEN bits are 1.
  - Status goes to 0 only when all bits are 0.
  - Otherwise status holds.
  - Status is evaluated in the cycle after the tick.
- **Per-button FSM (states IDLE, PRESSED, REPEAT)**, with a per-button tick counter of width $clog2(max(HOLD_MS, REPEAT_MS)):
  - IDLE → PRESSED when status rises: press pulse, counter cleared.
  - PRESSED: counter increments on each tick. When the counter reaches HOLD_MS-1 on a tick: go to REPEAT, press pulse, counter cleared.
  - REPEAT: held_o = 1. Counter increments on each tick. On reaching REPEAT_MS-1: press pulse, counter cleared, stay in REPEAT.
  - PRESSED or REPEAT → IDLE when status falls: release pulse, counter cleared, no press pulse.
- **Simultaneous events:** a status fall always wins over a pending hold or repeat expiry in the same cycle. The result is a release pulse only.
- **Independence:** the four buttons are fully independent; several buttons may pulse in the same cycle.

## Timing
- **Reset (synchronous, `reset` = 1 at a rising edge)** sets:
  - divider = 0, synchronisers = 0, shift registers = 0;
  - all FSMs to IDLE, all counters = 0;
  - every output = 0.
- **Reset mid-operation:** a button held through reset reports nothing until SHIFT_LEN fresh 1 samples have been taken after reset.
- **First tick:** tick_1ms_o first asserts in the TICK_PERIOD-th cycle after reset deasserts.
- **Press/release latency:** status, press and release pulses are registered. They assert in the cycle after the tick whose sample completes the all-1 (or all-0) register.
- **Input-to-register delay:** 2 synchroniser cycles plus the wait for the next tick.
- **Auto-repeat timing:**
  - First repeat pulse comes HOLD_MS ticks after the initial press pulse.
  - Subsequent pulses come every REPEAT_MS ticks.
  - All repeat pulses are one cycle after their tick.
- **Pulse width:** every pulse is exactly one cycle wide. press_pulse_o and release_pulse_o are never high together for the same bit.

## Test plan
Scenarios 1–4 use TICK_PERIOD=4, SHIFT_LEN=4, HOLD_MS=5, REPEAT_MS=2.
- **Reset values:** hold reset 3 cycles, then release with buttons idle.
  - During and after reset, all outputs are 0.
  - tick_1ms_o first appears in cycle 4 after deassert, then every 4 cycles.
- **Clean press of button 0:**
  - Input is 1 (pressed) for 30 ticks.
  - press_pulse_o[0] gives one pulse, one cycle after the 4th sampling tick; button_status_o[0] = 1 from that cycle.
  - After 5 more ticks, held_o[0] = 1 and a second press pulse is issued.
  - Further pulses follow every 2 ticks.
- **Bounce rejection:** button 1 sampled as pattern 1,0,1,1,0,1 then steady 1.
  - No pulse appears until four consecutive 1 samples.
  - Exactly one press pulse; no release pulse.
- **Release during repeat:** with button 0 in REPEAT, drive the input to 0.
  - release_pulse_o[0] asserts once, one cycle after the 4th 0 sample.
  - held_o[0] drops in the same cycle; no further press pulses.
- **Collision:** arrange the 4th 0 sample on the same tick as a REPEAT_MS expiry.
  - Result is a release pulse only; press_pulse_o stays 0.
- **Multi-button and reset mid-hold:**
  - Buttons 2 and 3 pressed on the same tick: both press pulses in the same cycle.
  - Assert reset while both are held: all outputs = 0 next cycle.
  - Keep holding: a new press pulse appears only after 4 post-reset ticks.
